// File: rtl/seg_decoder.sv
// ---------------------------------------------------------------------------
// seg_decoder
//
// Reads two active-low 7-segment displays (tens and units) that change
// asynchronously to clk_i. It waits until the synchronized pattern pair has
// been stable for STABLE_CYCLES cycles and then decodes it into BCD digits
// and a binary value. It flags pairs that cannot be decoded.
//
// Ports
//   clk_i      : system clock, all state on the rising edge
//   rst_ni     : asynchronous active-low reset
//   s1_seg_i   : tens segments {a,b,c,d,e,f,g}, bit6 = a, 0 = lit
//   s2_seg_i   : units segments, same ordering and polarity
//   tens_o     : last legally decoded tens digit (0..9)
//   units_o    : last legally decoded units digit (0..9)
//   value_o    : tens_o*10 + units_o (0..99)
//   valid_o    : one-cycle pulse when tens_o/units_o/value_o take a new value
//   err_o      : last accepted pattern pair was illegal
//   err_cnt_o  : saturating count of accepted illegal pairs
// ---------------------------------------------------------------------------
module seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] s1_seg_i,
  input  logic [6:0] s2_seg_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic [6:0] value_o,
  output logic       valid_o,
  output logic       err_o,
  output logic [7:0] err_cnt_o
);

  localparam logic [23:0] STABLE    = 24'(STABLE_CYCLES);
  // The move to DECODE happens on the edge where the counter reaches
  // STABLE-1, so the comparison is made against the value one below that.
  localparam logic [23:0] STABLE_M2 = 24'(STABLE_CYCLES - 2);
  localparam logic [6:0]  BLANK     = 7'b111_1111;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state_q;
  logic [13:0] sync1_q;
  logic [13:0] sync2_q;
  logic [13:0] prev_q;
  logic [23:0] cnt_q;
  logic [3:0]  tens_q;
  logic [3:0]  units_q;
  logic [6:0]  value_q;
  logic        valid_q;
  logic        err_q;
  logic [7:0]  err_cnt_q;
  logic        first_q;

  logic        changed_d;
  logic        tens_ok_d;
  logic        units_ok_d;
  logic        pair_ok_d;
  logic [3:0]  tens_d;
  logic [3:0]  units_d;
  logic [6:0]  value_d;
  logic        new_value_d;
  logic [4:0]  tens_lut_d;
  logic [4:0]  units_lut_d;

  // Returns {legal, digit}; the blank pattern is not legal here, the tens
  // digit handles it separately.
  function automatic logic [4:0] seg_to_digit(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b000_0001: r = 5'b1_0000;
      7'b100_1111: r = 5'b1_0001;
      7'b001_0010: r = 5'b1_0010;
      7'b000_0110: r = 5'b1_0011;
      7'b100_1100: r = 5'b1_0100;
      7'b010_0100: r = 5'b1_0101;
      7'b010_0000: r = 5'b1_0110;
      7'b000_1111: r = 5'b1_0111;
      7'b000_0000: r = 5'b1_1000;
      7'b000_0100: r = 5'b1_1001;
      default:     r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // prev_q holds the pair that was stable through the counting window, so
  // decoding it is safe even if a new change lands during DECODE.
  always_comb begin
    changed_d   = (sync2_q != prev_q);
    tens_lut_d  = seg_to_digit(prev_q[13:7]);
    units_lut_d = seg_to_digit(prev_q[6:0]);
    if (prev_q[13:7] == BLANK) begin
      tens_ok_d = 1'b1;
      tens_d    = 4'd0;
    end else begin
      tens_ok_d = tens_lut_d[4];
      tens_d    = tens_lut_d[3:0];
    end
    units_ok_d  = units_lut_d[4];
    units_d     = units_lut_d[3:0];
    pair_ok_d   = tens_ok_d && units_ok_d;
    // tens*10 = tens*8 + tens*2; max 99 fits in 7 bits.
    value_d     = {tens_d, 3'b000} + {2'b00, tens_d, 1'b0} + {3'b000, units_d};
    new_value_d = first_q || (tens_d != tens_q) || (units_d != units_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      prev_q    <= '1;
      cnt_q     <= '0;
      state_q   <= SETTLE;
      tens_q    <= '0;
      units_q   <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      first_q   <= 1'b1;
    end else begin
      sync1_q <= {s1_seg_i, s2_seg_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;

      if (changed_d) begin
        cnt_q <= '0;
      end else if (cnt_q != STABLE) begin
        cnt_q <= cnt_q + 24'd1;
      end

      case (state_q)
        SETTLE: begin
          // A change on the same edge wins: the counter clears and we stay.
          if (!changed_d && (cnt_q == STABLE_M2)) begin
            state_q <= DECODE;
          end
        end
        DECODE: begin
          state_q <= HOLD;
          if (pair_ok_d) begin
            tens_q  <= tens_d;
            units_q <= units_d;
            value_q <= value_d;
            valid_q <= new_value_d;
            err_q   <= 1'b0;
            first_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        end
        HOLD: begin
          // A counter below saturation means a change slipped in during
          // DECODE; it must be settled again rather than missed.
          if (changed_d || (cnt_q != STABLE)) begin
            state_q <= SETTLE;
          end
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign tens_o    = tens_q;
  assign units_o   = units_q;
  assign value_o   = value_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_seg_decoder.sv
module tb_seg_decoder;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] s1 = 7'h7f;
  logic [6:0] s2 = 7'h7f;
  logic [3:0] tens_o;
  logic [3:0] units_o;
  logic [6:0] value_o;
  logic       valid_o;
  logic       err_o;
  logic [7:0] err_cnt_o;

  seg_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .s1_seg_i (s1),
    .s2_seg_i (s2),
    .tens_o   (tens_o),
    .units_o  (units_o),
    .value_o  (value_o),
    .valid_o  (valid_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int u;
    int v;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;

  // Reference model of held state
  int m_t, m_u, m_err, m_cnt;
  bit m_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 0..9 for digits, 10 for blank, -1 for anything else
  function automatic int seg2dig(input logic [6:0] p);
    case (p)
      7'b0000001: return 0;
      7'b1001111: return 1;
      7'b0010010: return 2;
      7'b0000110: return 3;
      7'b1001100: return 4;
      7'b0100100: return 5;
      7'b0100000: return 6;
      7'b0001111: return 7;
      7'b0000000: return 8;
      7'b0000100: return 9;
      7'b1111111: return 10;
      default:    return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0; m_u = 0; m_err = 0; m_cnt = 0; m_first = 1'b1;
  endtask

  task automatic model_accept(input logic [6:0] a, input logic [6:0] b);
    int td, ud;
    exp_t e;
    td = seg2dig(a);
    ud = seg2dig(b);
    if (td == 10) td = 0;
    if (td >= 0 && td <= 9 && ud >= 0 && ud <= 9) begin
      if (m_first || td != m_t || ud != m_u) begin
        e.t = td; e.u = ud; e.v = td * 10 + ud;
        exp_q.push_back(e);
      end
      m_t = td; m_u = ud; m_first = 1'b0; m_err = 0;
    end else begin
      m_err = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  // Scoreboard: every VALID pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", valid_o, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_tens", tens_o, e.t);
        check("valid_units", units_o, e.u);
        check("valid_value", value_o, e.v);
      end
    end
  end

  task automatic check_outputs(input string tag);
    check({tag, "_tens"}, tens_o, m_t);
    check({tag, "_units"}, units_o, m_u);
    check({tag, "_value"}, value_o, m_t * 10 + m_u);
    check({tag, "_err"}, err_o, m_err);
    check({tag, "_errcnt"}, err_cnt_o, m_cnt);
    check({tag, "_pending_valid"}, exp_q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tens"}, tens_o, 0);
    check({tag, "_units"}, units_o, 0);
    check({tag, "_value"}, value_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_errcnt"}, err_cnt_o, 0);
  endtask

  // Called right after the driving edge: VALID must appear exactly on the
  // 7th edge (2 sync + 4 stable + 1 decode).
  task automatic check_latency(input string tag);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      check(tag, valid_o, (k == 7) ? 1 : 0);
    end
  endtask

  task automatic accept(input string tag, input logic [6:0] a, input logic [6:0] b);
    @(posedge clk);
    #1;
    s1 = a;
    s2 = b;
    model_accept(a, b);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");

    // First legal accept: 01, exact latency from reset release
    s1 = 7'b0000001;
    s2 = 7'b1001111;
    model_accept(s1, s2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_latency("first_latency");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("first01");

    // 42, then glitching units never settles, then 47
    accept("hold42", 7'b1001100, 7'b0010010);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      s2[0] = ~s2[0];
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    check_outputs("toggle42");
    accept("settle47", 7'b1001100, 7'b0001111);

    // Blank tens, then blank units is illegal
    accept("blank05", 7'b1111111, 7'b0100100);
    accept("blank_units", 7'b1111111, 7'b1111111);

    // 99, short glitch, same pair again -> no new VALID
    accept("first99", 7'b0000100, 7'b0000100);
    @(posedge clk);
    #1;
    s1 = 7'b1111111;
    repeat (2) @(posedge clk);
    #1;
    s1 = 7'b0000100;
    accept("again99", 7'b0000100, 7'b0000100);

    // Alternate illegal / legal 33 until ERR_CNT saturates
    for (int i = 0; i < 300; i++) begin
      accept("alt_bad", 7'b1010101, 7'b1010101);
      accept("alt_33", 7'b0000110, 7'b0000110);
    end
    check("errcnt_saturated", err_cnt_o, 255);

    // Reset two cycles before DECODE of 88 abandons it
    @(posedge clk);
    #1;
    s1 = 7'b0000000;
    s2 = 7'b0000000;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_accept(s1, s2);
    check_latency("post_reset_latency");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("post_reset88");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
